// File: rtl/md_cart_rom_responder.sv
// Cart-bus ROM responder: serves console read strobes from a last-word buffer and a
// sequential prefetch buffer, falling back to a req/ack backing-store fetch on a miss.
`timescale 1ns/1ps
module md_cart_rom_responder #(
    parameter int                ADDR_W   = 21,
    parameter logic [ADDR_W-1:0] ROM_MASK = 21'h1FFFFF,
    parameter int                SETTLE   = 2,
    parameter bit                PREFETCH = 1'b1
) (
    input  logic              MCLK,
    input  logic              ext_reset_n,
    input  logic [ADDR_W-1:0] cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    output logic [15:0]       cart_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       miss_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_FETCH  = 3'd3,
        ST_PREF   = 3'd4
    } state_e;

    localparam logic [3:0]        SETTLE_C = 4'(SETTLE);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] lat_q, lat_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              hold_q, hold_d;
    logic              pend_q, pend_d;
    logic              arm_q;
    logic [15:0]       data_q, data_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       miss_q, miss_d;
    logic [ADDR_W-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
    logic [15:0]       cur_dat_q, cur_dat_d, nxt_dat_q, nxt_dat_d;
    logic              cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;

    logic              rd;
    logic              take;
    logic              new_acc;
    logic [ADDR_W-1:0] a_m;
    logic [ADDR_W-1:0] lat_inc;
    logic [3:0]        cnt_inc;

    assign rd      = cart_cs & cart_oe;
    assign a_m     = cart_address & ROM_MASK;
    assign lat_inc = (lat_q + ADDR_ONE) & ROM_MASK;
    assign cnt_inc = {1'b0, cnt_q} + 4'd1;
    // An ack counts only once the request has been visible for a full cycle.
    assign take    = req_q & arm_q & mem_ack;
    // hold_q blocks re-serving the same strobe until rd drops or the address moves.
    assign new_acc = rd & (~hold_q | (a_m != lat_q));

    assign cart_data  = data_q;
    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign miss_count = miss_q;

    // Next-state and datapath updates for the lookup/fetch FSM.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q & rd;
        pend_d    = pend_q;
        data_d    = data_q;
        req_d     = req_q;
        addr_d    = addr_q;
        miss_d    = miss_q;
        cur_tag_d = cur_tag_q;
        cur_dat_d = cur_dat_q;
        cur_v_d   = cur_v_q;
        nxt_tag_d = nxt_tag_q;
        nxt_dat_d = nxt_dat_q;
        nxt_v_d   = nxt_v_q;
        case (state_q)
            ST_IDLE: begin
                if (new_acc) begin
                    lat_d   = a_m;
                    cnt_d   = 3'd1;
                    hold_d  = 1'b0;
                    state_d = (SETTLE_C <= 4'd1) ? ST_LOOKUP : ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!rd) begin
                    state_d = ST_IDLE;
                end else if (a_m != lat_q) begin
                    lat_d = a_m;
                    cnt_d = 3'd1;
                end else begin
                    cnt_d   = cnt_inc[2:0];
                    state_d = (cnt_inc >= SETTLE_C) ? ST_LOOKUP : ST_SETTLE;
                end
            end
            ST_LOOKUP: begin
                hold_d = rd;
                if (cur_v_q && (cur_tag_q == lat_q)) begin
                    data_d  = cur_dat_q;
                    state_d = ST_IDLE;
                end else if (nxt_v_q && (nxt_tag_q == lat_q)) begin
                    data_d    = nxt_dat_q;
                    cur_tag_d = nxt_tag_q;
                    cur_dat_d = nxt_dat_q;
                    cur_v_d   = 1'b1;
                    nxt_v_d   = 1'b0;
                    if (PREFETCH) begin
                        req_d   = 1'b1;
                        addr_d  = lat_inc;
                        state_d = ST_PREF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    req_d   = 1'b1;
                    addr_d  = lat_q;
                    miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (take) begin
                    data_d    = mem_rdata;
                    cur_tag_d = addr_q;
                    cur_dat_d = mem_rdata;
                    cur_v_d   = 1'b1;
                    if (PREFETCH) begin
                        addr_d  = lat_inc;
                        state_d = ST_PREF;
                    end else begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PREF: begin
                // A new strobe arriving here is settled in the background.
                if (!rd) begin
                    pend_d = 1'b0;
                end else if (!pend_q) begin
                    if (new_acc) begin
                        pend_d = 1'b1;
                        lat_d  = a_m;
                        cnt_d  = 3'd1;
                        hold_d = 1'b0;
                    end else begin
                        pend_d = 1'b0;
                    end
                end else if (a_m != lat_q) begin
                    lat_d = a_m;
                    cnt_d = 3'd1;
                end else if ({1'b0, cnt_q} < SETTLE_C) begin
                    cnt_d = cnt_inc[2:0];
                end else begin
                    cnt_d = cnt_q;
                end
                if (take) begin
                    nxt_tag_d = addr_q;
                    nxt_dat_d = mem_rdata;
                    nxt_v_d   = 1'b1;
                    req_d     = 1'b0;
                    if (pend_d) begin
                        state_d = ({1'b0, cnt_d} >= SETTLE_C) ? ST_LOOKUP : ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    pend_d = 1'b0;
                end else begin
                    state_d = ST_PREF;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, buffer and output registers.
    always_ff @(posedge MCLK or negedge ext_reset_n) begin
        if (!ext_reset_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            cnt_q     <= 3'd0;
            hold_q    <= 1'b0;
            pend_q    <= 1'b0;
            arm_q     <= 1'b0;
            data_q    <= 16'h0000;
            req_q     <= 1'b0;
            addr_q    <= '0;
            miss_q    <= 16'h0000;
            cur_tag_q <= '0;
            cur_dat_q <= 16'h0000;
            cur_v_q   <= 1'b0;
            nxt_tag_q <= '0;
            nxt_dat_q <= 16'h0000;
            nxt_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            arm_q     <= req_q & ~take;
            data_q    <= data_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            miss_q    <= miss_d;
            cur_tag_q <= cur_tag_d;
            cur_dat_q <= cur_dat_d;
            cur_v_q   <= cur_v_d;
            nxt_tag_q <= nxt_tag_d;
            nxt_dat_q <= nxt_dat_d;
            nxt_v_q   <= nxt_v_d;
        end
    end

endmodule
